vector_stripmine_unit: RTL and testbench

VECTOR_STRIPMINE_UNIT -- requirements
Module: vector_stripmine_unit

---
 rtl/vec_pkg.sv | 30 +++
 rtl/vector_lane_alu.sv | 38 +++
 rtl/vector_stripmine_unit.sv | 169 ++++++++++++++++
 tb/tb_vector_stripmine_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared op encodings, FSM states and small helpers for the vector strip-mine unit.
// Pure declarations; no timing or flow control here.
package vec_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_MINU = 4'd8,
      OP_MAXU = 4'd9,
      OP_MIN  = 4'd10,
      OP_MAX  = 4'd11
   } vec_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } vec_state_e;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/vector_lane_alu.sv
// One element lane: combinational ELEN-bit ALU, modulo 2^ELEN; codes 12-15 give zero.
// Zero latency, no flow control.
module vector_lane_alu
   import vec_pkg::*;
#(
   parameter int ELEN = 32
) (
   input  vec_op_e         op,
   input  logic [ELEN-1:0] a,
   input  logic [ELEN-1:0] b,
   output logic [ELEN-1:0] y
);

   localparam int SHW = $clog2(ELEN);

   logic [SHW-1:0] sh;
   assign sh = b[SHW-1:0];

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SLL:  y = a << sh;
         OP_SRL:  y = a >> sh;
         OP_SRA:  y = ELEN'($signed(a) >>> sh);
         OP_MINU: y = (a < b) ? a : b;
         OP_MAXU: y = (a > b) ? a : b;
         OP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
         OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/vector_stripmine_unit.sv
// Strip-mines one vector op over NUM_LANES-wide beats; out_valid comes beats+1 cycles after accept.
// Accepts only in IDLE; result is held in DONE until out_ready, flush aborts from any state.
module vector_stripmine_unit
   import vec_pkg::*;
#(
   parameter int VLEN      = 128,
   parameter int ELEN      = 32,
   parameter int NUM_LANES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          vl,
   input  logic                 vta,
   input  logic                 vm,
   input  logic [3:0]           vec_op,
   input  logic [VLEN-1:0]      vec_src1,
   input  logic [VLEN-1:0]      vec_src2,
   input  logic [VLEN-1:0]      vd_old,
   input  logic [VLEN/ELEN-1:0] vmask,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [VLEN-1:0]      vec_result,
   output logic                 busy
);

   localparam int VLMAX     = VLEN / ELEN;
   localparam int BEATS_MAX = VLMAX / NUM_LANES;
   localparam int BW        = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
   localparam int VLW       = $clog2(VLMAX + 1);

   vec_state_e            state_q, state_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [BW-1:0]         last_beat_q, last_beat_d;
   logic [VLW-1:0]        vl_eff_q, vl_eff_d;
   logic [3:0]            op_q, op_d;
   logic                  vm_q, vm_d;
   logic [VLMAX-1:0]      vmask_q, vmask_d;
   logic [VLEN-1:0]       src1_q, src1_d;
   logic [VLEN-1:0]       src2_q, src2_d;
   logic [VLEN-1:0]       result_q, result_d;

   logic [VLW-1:0]        vl_eff_c;
   logic [BW-1:0]         last_beat_c;
   logic [NUM_LANES*ELEN-1:0] lane_y;

   assign vl_eff_c    = (vl > 32'(VLMAX)) ? VLW'(VLMAX) : VLW'(vl);
   assign last_beat_c = BW'(ceil_div(32'(vl_eff_c), NUM_LANES) - 32'd1);

   // Each lane picks its operands for the current beat from the captured registers.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [ELEN-1:0] lane_a;
      logic [ELEN-1:0] lane_b;

      always_comb begin
         lane_a = '0;
         lane_b = '0;
         for (int bt = 0; bt < BEATS_MAX; bt++) begin
            if (beat_q == BW'(bt)) begin
               lane_a = src1_q[(bt*NUM_LANES + l)*ELEN +: ELEN];
               lane_b = src2_q[(bt*NUM_LANES + l)*ELEN +: ELEN];
            end
         end
      end

      vector_lane_alu #(.ELEN(ELEN)) u_alu (
         .op (vec_op_e'(op_q)),
         .a  (lane_a),
         .b  (lane_b),
         .y  (lane_y[l*ELEN +: ELEN])
      );
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      last_beat_d = last_beat_q;
      vl_eff_d    = vl_eff_q;
      op_d        = op_q;
      vm_d        = vm_q;
      vmask_d     = vmask_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      result_d    = result_q;

      if (flush) begin
         state_d = ST_IDLE;
         beat_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  vl_eff_d    = vl_eff_c;
                  last_beat_d = last_beat_c;
                  op_d        = vec_op;
                  vm_d        = vm;
                  vmask_d     = vmask;
                  src1_d      = vec_src1;
                  src2_d      = vec_src2;
                  beat_d      = '0;
                  // Tail and masked-off elements resolve now; beats only overwrite active ones.
                  for (int e = 0; e < VLMAX; e++) begin
                     result_d[e*ELEN +: ELEN] = (VLW'(e) >= vl_eff_c && vta) ?
                                                {ELEN{1'b1}} : vd_old[e*ELEN +: ELEN];
                  end
                  if (vl_eff_c == '0) begin
                     result_d = vd_old;
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               for (int e = 0; e < VLMAX; e++) begin
                  if (BW'(e / NUM_LANES) == beat_q && VLW'(e) < vl_eff_q &&
                      (vm_q || vmask_q[e])) begin
                     result_d[e*ELEN +: ELEN] = lane_y[(e % NUM_LANES)*ELEN +: ELEN];
                  end
               end
               if (beat_q == last_beat_q) begin
                  state_d = ST_DONE;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + BW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         last_beat_q <= '0;
         vl_eff_q    <= '0;
         op_q        <= '0;
         vm_q        <= 1'b0;
         vmask_q     <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         last_beat_q <= last_beat_d;
         vl_eff_q    <= vl_eff_d;
         op_q        <= op_d;
         vm_q        <= vm_d;
         vmask_q     <= vmask_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         result_q    <= result_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign vec_result = result_q;

endmodule

// File: tb/tb_vector_stripmine_unit.sv
// Directed bench for vector_stripmine_unit at default parameters (4 elements, 2 lanes).
module tb_vector_stripmine_unit;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  vl = '0;
   logic         vta = 1'b0;
   logic         vm = 1'b1;
   logic [3:0]   vec_op = '0;
   logic [127:0] vec_src1 = '0;
   logic [127:0] vec_src2 = '0;
   logic [127:0] vd_old = '0;
   logic [3:0]   vmask = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] vec_result;
   logic         busy;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] V55 = {4{32'h0000_0055}};

   vector_stripmine_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .vl         (vl),
      .vta        (vta),
      .vm         (vm),
      .vec_op     (vec_op),
      .vec_src1   (vec_src1),
      .vec_src2   (vec_src2),
      .vd_old     (vd_old),
      .vmask      (vmask),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .vec_result (vec_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request (state must be IDLE) and counts edges until out_valid, max 20.
   task automatic run_op(input logic [3:0] op, input logic [31:0] len, input logic ta,
                         input logic unmasked, input logic [3:0] mask,
                         input logic [127:0] s1, input logic [127:0] s2,
                         input logic [127:0] old, output int cyc);
      vec_op = op; vl = len; vta = ta; vm = unmasked; vmask = mask;
      vec_src1 = s1; vec_src2 = s2; vd_old = old;
      in_valid = 1'b1;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         in_valid = 1'b0;
         cyc++;
         if (out_valid) break;
      end
   endtask

   // Returns to IDLE; a request offered during DONE must not be taken.
   task automatic drain(input string tag);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_done_in_ready"}, in_ready, 1'b0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_out_valid"}, out_valid, 1'b0);
      chk({tag, "_idle_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      int cyc;
      logic [127:0] held;

      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", vec_result, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      step();

      // ADD, 2 beats, then 5 stalled cycles in DONE
      run_op(4'd0, 32'd4, 1'b0, 1'b1, 4'b0000,
             128'h00000004_00000003_00000002_00000001,
             {4{32'd10}}, '0, cyc);
      chk("add_latency", 128'(cyc), 128'd3);
      chk("add_result", vec_result, 128'h0000000e_0000000d_0000000c_0000000b);
      held = vec_result;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_result", vec_result, held);
         chk("stall_in_ready", in_ready, 1'b0);
      end
      drain("add");

      // SUB vl=3, tail undisturbed then tail agnostic
      run_op(4'd1, 32'd3, 1'b0, 1'b1, 4'b0000,
             128'h00000007_00000000_00000005_00000009,
             128'h00000001_00000001_00000001_00000002,
             128'h0000DEAD_11111111_22222222_33333333, cyc);
      chk("sub_tu_latency", 128'(cyc), 128'd3);
      chk("sub_tu_result", vec_result, 128'h0000DEAD_FFFFFFFF_00000004_00000007);
      drain("sub_tu");
      run_op(4'd1, 32'd3, 1'b1, 1'b1, 4'b0000,
             128'h00000007_00000000_00000005_00000009,
             128'h00000001_00000001_00000001_00000002,
             128'h0000DEAD_11111111_22222222_33333333, cyc);
      chk("sub_ta_result", vec_result, 128'hFFFFFFFF_FFFFFFFF_00000004_00000007);
      drain("sub_ta");

      // Signed MAX with mask 0101: elements 0,2 active
      run_op(4'd11, 32'd4, 1'b0, 1'b0, 4'b0101,
             128'hFFFFFFFF_FFFFFFF9_00000005_00000002,
             '0, V55, cyc);
      chk("max_mask_result", vec_result, 128'h00000055_00000000_00000055_00000002);
      drain("max");

      // SRA vl=2: single beat, shift amount uses low 5 bits of src2
      run_op(4'd7, 32'd2, 1'b0, 1'b1, 4'b0000,
             128'h00000000_00000000_00000100_80000000,
             128'h00000000_00000000_00000024_00000004,
             V55, cyc);
      chk("sra_latency", 128'(cyc), 128'd2);
      chk("sra_result", vec_result, 128'h00000055_00000055_00000010_F8000000);
      drain("sra");

      // Reserved op code gives zeros
      run_op(4'd13, 32'd4, 1'b0, 1'b1, 4'b0000,
             128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, {4{32'h1}}, V55, cyc);
      chk("op13_result", vec_result, '0);
      drain("op13");

      // vl=0 returns vd_old (even tail-agnostic) after 1 cycle
      run_op(4'd0, 32'd0, 1'b1, 1'b1, 4'b0000, {4{32'h1}}, {4{32'h1}}, V55, cyc);
      chk("vl0_latency", 128'(cyc), 128'd1);
      chk("vl0_result", vec_result, V55);
      drain("vl0");

      // vl=100 clamps to 4 elements, 2 beats
      run_op(4'd4, 32'd100, 1'b1, 1'b1, 4'b0000,
             128'hFFFF0000_0000FFFF_AAAAAAAA_00000001,
             128'h0F0F0F0F_0F0F0F0F_55555555_00000003, '0, cyc);
      chk("vl100_latency", 128'(cyc), 128'd3);
      chk("vl100_result", vec_result, 128'hF0F00F0F_0F0FF0F0_FFFFFFFF_00000002);
      drain("vl100");

      // Flush during EXEC
      vec_op = 4'd0; vl = 32'd4; vm = 1'b1; vta = 1'b0;
      vec_src1 = {4{32'h1}}; vec_src2 = {4{32'h1}}; vd_old = V55;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("flush_pre_busy", busy, 1'b1);
      flush = 1'b1;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b0;
      chk("flush_busy", busy, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_no_out_valid", out_valid, 1'b0);
      end

      // Reset pulse during EXEC
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("rstx_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rstx_out_valid", out_valid, 1'b0);
      chk("rstx_busy", busy, 1'b0);
      chk("rstx_result", vec_result, '0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rstx_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rstx_no_out_valid", out_valid, 1'b0);
      end

      // Recovery after reset
      run_op(4'd8, 32'd4, 1'b0, 1'b1, 4'b0000,
             128'h00000009_00000002_FFFFFFFF_00000005,
             128'h00000003_00000007_00000001_00000005, '0, cyc);
      chk("minu_latency", 128'(cyc), 128'd3);
      chk("minu_result", vec_result, 128'h00000003_00000002_00000001_00000005);
      drain("minu");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
